// File: rtl/auto_enhance_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : auto_enhance_ctrl
//  Description : Closed-loop controller for the enhance stage. Measures the
//                per-frame mean S and V of the HSV pixel stream, compares each
//                mean against a target with a deadband and holds inc/dec
//                commands for the following frame.
//                Optional saturation loop: define AUTO_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module auto_enhance_ctrl #(
   parameter int PIX_CNT_W = 19,
   parameter int DEADBAND  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        pixel_valid,
   input  logic [23:0] hsv_in,
   input  logic        auto_en,
   input  logic [7:0]  target_s,
   input  logic [7:0]  target_v,
   output logic        inc_saturation,
   output logic        dec_saturation,
   output logic        inc_brightness,
   output logic        dec_brightness,
   output logic        enhance_user_in_en,
   output logic [7:0]  mean_s,
   output logic [7:0]  mean_v,
   output logic        stats_valid,
   output logic        busy
);

   localparam int         SUM_W     = 8 + PIX_CNT_W;
   localparam logic [8:0] DB9       = 9'(DEADBAND);
   localparam logic [1:0] ST_ACCUM  = 2'd0;
`ifdef AUTO_SAT_EN
   localparam logic [1:0] ST_DIV_S  = 2'd1;
`endif
   localparam logic [1:0] ST_DIV_V  = 2'd2;
   localparam logic [1:0] ST_DECIDE = 2'd3;
`ifdef AUTO_SAT_EN
   localparam logic [1:0] FIRST_DIV = ST_DIV_S;
`else
   localparam logic [1:0] FIRST_DIV = ST_DIV_V;
`endif

   logic [1:0]           state_q, state_d;
   logic                 vsync_q;
   logic [SUM_W-1:0]     sum_v_q;
   logic [PIX_CNT_W-1:0] cnt_q;
   logic [SUM_W-1:0]     rem_q;
   logic [PIX_CNT_W-1:0] dcnt_q;
   logic [2:0]           bit_q;
   logic [7:0]           quot_q;
   logic                 cmd_inc_v_q, cmd_dec_v_q, cmd_inc_v_d, cmd_dec_v_d;
   logic                 inc_v_q, dec_v_q, en_q, stats_q;
   logic [7:0]           mean_v_q;

   logic                 w_fall, w_cnt_full, w_cnt_zero, w_dividing;
   logic                 w_decide, w_clear, w_busy;
   logic [SUM_W-1:0]     w_shift, w_rem_sub;
   logic                 w_ge;
   logic [7:0]           w_q_next;
   logic                 w_inc_v, w_dec_v;

   assign w_fall     = ~vsync & vsync_q;
   assign w_cnt_full = &cnt_q;
   assign w_cnt_zero = (cnt_q == '0);

   // One restoring-division step: trial-subtract count << bit from remainder
   assign w_shift   = SUM_W'(dcnt_q) << bit_q;
   assign w_ge      = (rem_q >= w_shift);
   assign w_rem_sub = rem_q - w_shift;
   assign w_q_next  = {quot_q[6:0], w_ge};

   // Deadband decision in 9 bits so mean+DEADBAND and target+DEADBAND never wrap
   assign w_inc_v = (({1'b0, quot_q} + DB9) < {1'b0, target_v});
   assign w_dec_v = ({1'b0, quot_q} > ({1'b0, target_v} + DB9));

`ifdef AUTO_SAT_EN
   logic [SUM_W-1:0] sum_s_q, dsum_v_q;
   logic [7:0]       qs_q, mean_s_q;
   logic             cmd_inc_s_q, cmd_dec_s_q, cmd_inc_s_d, cmd_dec_s_d;
   logic             inc_s_q, dec_s_q;
   logic             w_inc_s, w_dec_s;

   assign w_dividing = (state_q == ST_DIV_S) || (state_q == ST_DIV_V);
   assign w_inc_s    = (({1'b0, qs_q} + DB9) < {1'b0, target_s});
   assign w_dec_s    = ({1'b0, qs_q} > ({1'b0, target_s} + DB9));
`else
   logic w_unused;
   assign w_dividing = (state_q == ST_DIV_V);
   assign w_unused   = ^{hsv_in[15:8], target_s};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_ACCUM;
      else     state_q <= state_d;
   end

   // Next state: a vsync falling edge always restarts the sequence
   always_comb begin
      state_d = state_q;
      if (w_fall) begin
         state_d = w_cnt_zero ? ST_ACCUM : FIRST_DIV;
      end else begin
         case (state_q)
`ifdef AUTO_SAT_EN
            ST_DIV_S:  if (bit_q == 3'd0) state_d = ST_DIV_V;
`endif
            ST_DIV_V:  if (bit_q == 3'd0) state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_ACCUM;
            default:   state_d = state_q;
         endcase
      end
   end

   // FSM outputs: busy flag, decide/clear strobes and next command values
   always_comb begin
      w_busy      = (state_q != ST_ACCUM);
      w_decide    = (state_q == ST_DECIDE) && !w_fall;
      w_clear     = w_fall && w_cnt_zero;
      cmd_inc_v_d = cmd_inc_v_q;
      cmd_dec_v_d = cmd_dec_v_q;
`ifdef AUTO_SAT_EN
      cmd_inc_s_d = cmd_inc_s_q;
      cmd_dec_s_d = cmd_dec_s_q;
`endif
      if (w_clear) begin
         cmd_inc_v_d = 1'b0;
         cmd_dec_v_d = 1'b0;
`ifdef AUTO_SAT_EN
         cmd_inc_s_d = 1'b0;
         cmd_dec_s_d = 1'b0;
`endif
      end else if (w_decide) begin
         cmd_inc_v_d = w_inc_v;
         cmd_dec_v_d = w_dec_v;
`ifdef AUTO_SAT_EN
         cmd_inc_s_d = w_inc_s;
         cmd_dec_s_d = w_dec_s;
`endif
      end
   end

   // Frame accumulators; the cycle-T pixel already belongs to the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_v_q <= '0;
         cnt_q   <= '0;
`ifdef AUTO_SAT_EN
         sum_s_q <= '0;
`endif
      end else if (w_fall) begin
         sum_v_q <= pixel_valid ? SUM_W'(hsv_in[7:0]) : '0;
         cnt_q   <= pixel_valid ? PIX_CNT_W'(1) : '0;
`ifdef AUTO_SAT_EN
         sum_s_q <= pixel_valid ? SUM_W'(hsv_in[15:8]) : '0;
`endif
      end else if (pixel_valid && !w_cnt_full) begin
         sum_v_q <= sum_v_q + SUM_W'(hsv_in[7:0]);
         cnt_q   <= cnt_q + PIX_CNT_W'(1);
`ifdef AUTO_SAT_EN
         sum_s_q <= sum_s_q + SUM_W'(hsv_in[15:8]);
`endif
      end
   end

   // Divider: latch frame totals at vsync fall, then one quotient bit per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q    <= '0;
         dcnt_q   <= '0;
         bit_q    <= 3'd0;
         quot_q   <= 8'd0;
`ifdef AUTO_SAT_EN
         dsum_v_q <= '0;
         qs_q     <= 8'd0;
`endif
      end else if (w_fall) begin
         dcnt_q   <= cnt_q;
         bit_q    <= 3'd7;
         quot_q   <= 8'd0;
`ifdef AUTO_SAT_EN
         rem_q    <= sum_s_q;
         dsum_v_q <= sum_v_q;
`else
         rem_q    <= sum_v_q;
`endif
      end else if (w_dividing) begin
         rem_q  <= w_ge ? w_rem_sub : rem_q;
         quot_q <= w_q_next;
         bit_q  <= bit_q - 3'd1;
`ifdef AUTO_SAT_EN
         // Last saturation bit: keep mean S and seed the V division
         if ((state_q == ST_DIV_S) && (bit_q == 3'd0)) begin
            qs_q  <= w_q_next;
            rem_q <= dsum_v_q;
         end
`endif
      end
   end

   // Registered outputs; auto_en gates the commands but not the measurement
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q     <= 1'b0;
         cmd_inc_v_q <= 1'b0;
         cmd_dec_v_q <= 1'b0;
         inc_v_q     <= 1'b0;
         dec_v_q     <= 1'b0;
         en_q        <= 1'b0;
         stats_q     <= 1'b0;
         mean_v_q    <= 8'd0;
`ifdef AUTO_SAT_EN
         cmd_inc_s_q <= 1'b0;
         cmd_dec_s_q <= 1'b0;
         inc_s_q     <= 1'b0;
         dec_s_q     <= 1'b0;
         mean_s_q    <= 8'd0;
`endif
      end else begin
         vsync_q     <= vsync;
         cmd_inc_v_q <= cmd_inc_v_d;
         cmd_dec_v_q <= cmd_dec_v_d;
         inc_v_q     <= auto_en & cmd_inc_v_d;
         dec_v_q     <= auto_en & cmd_dec_v_d;
         en_q        <= auto_en;
         stats_q     <= w_decide;
         if (w_decide) mean_v_q <= quot_q;
`ifdef AUTO_SAT_EN
         cmd_inc_s_q <= cmd_inc_s_d;
         cmd_dec_s_q <= cmd_dec_s_d;
         inc_s_q     <= auto_en & cmd_inc_s_d;
         dec_s_q     <= auto_en & cmd_dec_s_d;
         if (w_decide) mean_s_q <= qs_q;
`endif
      end
   end

   assign inc_brightness     = inc_v_q;
   assign dec_brightness     = dec_v_q;
   assign enhance_user_in_en = en_q;
   assign mean_v             = mean_v_q;
   assign stats_valid        = stats_q;
   assign busy               = w_busy;
`ifdef AUTO_SAT_EN
   assign inc_saturation     = inc_s_q;
   assign dec_saturation     = dec_s_q;
   assign mean_s             = mean_s_q;
`else
   assign inc_saturation     = 1'b0;
   assign dec_saturation     = 1'b0;
   assign mean_s             = 8'd0;
`endif

endmodule
`default_nettype wire
